// File: rtl/cd_event_fifo.sv
// cd_event_fifo: debounces the c/d outputs of my_module and queues every
// accepted level change as a timestamped {ts, src, lvl} record. A consumer
// drains records over a valid/ready handshake. Overflow drops are flagged
// in a sticky ovf bit.
module cd_event_fifo #(
    parameter int X = 2,   // debounce length in cycles (>= 1)
    parameter int Y = 4,   // FIFO depth in entries (power of two, >= 2)
    parameter int Z = 3    // timestamp width in bits
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         c,
    input  logic         d,
    input  logic         clr_ovf,
    output logic         ev_valid,
    input  logic         ev_ready,
    output logic [Z+1:0] ev_data,
    output logic [1:0]   level,
    output logic         ovf
);

    localparam int CW = $clog2(X + 1);   // debounce counter width
    localparam int AW = $clog2(Y);       // FIFO pointer width
    localparam int W  = Z + 2;           // record width

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic       c_q;
    logic       d_q;
    logic [1:0] raw_q;      // {d_q, c_q}

    // Register the raw channels once before debouncing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            c_q <= 1'b0;
            d_q <= 1'b0;
        end else begin
            c_q <= c;
            d_q <= d;
        end
    end

    assign raw_q = {d_q, c_q};

    // ------------------------------------------------------------------
    // Per-channel debounce: channel 0 is C, channel 1 is D
    // ------------------------------------------------------------------
    logic [1:0] flip;       // debounced level toggles at the coming edge
    logic [1:0] lvl_nx;     // level after the coming edge

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          lvl_q;
            logic          lvl_d;
            logic          hit;

            // Count consecutive disagreeing cycles; flip once the run reaches X.
            always_comb begin
                cnt_d = '0;
                lvl_d = lvl_q;
                hit   = 1'b0;
                if (raw_q[gi] != lvl_q) begin
                    if (({1'b0, cnt_q} + (CW+1)'(1)) == (CW+1)'(X)) begin
                        lvl_d = ~lvl_q;
                        hit   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            // Debounce state registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    lvl_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    lvl_q <= lvl_d;
                end
            end

            assign flip[gi]   = hit;
            assign lvl_nx[gi] = lvl_d;
            assign level[gi]  = lvl_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Free-running timestamp
    // ------------------------------------------------------------------
    logic [Z-1:0] ts_q;

    // Timestamp advances every cycle and wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + Z'(1);
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] wr_ptr_d;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] rd_ptr_d;
    logic          ovf_q;
    logic          ovf_d;

    logic [AW:0]   free_slots;
    logic [W-1:0]  rec_c;
    logic [W-1:0]  rec_d;
    logic          we0;
    logic          we1;
    logic [W-1:0]  wd0;
    logic [W-1:0]  wd1;
    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;
    logic [1:0]    nwr;
    logic          drop;
    logic          pop;

    // Room is judged on the count at the start of the cycle, so a pop in
    // the same cycle never makes space for a push.
    assign free_slots = (AW+1)'(Y) - count_q;
    assign rec_c      = {ts_q, 1'b0, lvl_nx[0]};
    assign rec_d      = {ts_q, 1'b1, lvl_nx[1]};
    assign wa0        = wr_ptr_q;
    assign wa1        = wr_ptr_q + AW'(1);
    assign pop        = ev_valid && ev_ready;

    // Decide which new records fit; C always takes precedence over D.
    always_comb begin
        we0  = 1'b0;
        we1  = 1'b0;
        wd0  = rec_c;
        wd1  = rec_d;
        nwr  = 2'd0;
        drop = 1'b0;
        case (flip)
            2'b01: begin
                if (free_slots != '0) begin
                    we0 = 1'b1;
                    nwr = 2'd1;
                end else begin
                    drop = 1'b1;
                end
            end
            2'b10: begin
                if (free_slots != '0) begin
                    we0 = 1'b1;
                    wd0 = rec_d;
                    nwr = 2'd1;
                end else begin
                    drop = 1'b1;
                end
            end
            2'b11: begin
                if (free_slots >= (AW+1)'(2)) begin
                    we0 = 1'b1;
                    we1 = 1'b1;
                    nwr = 2'd2;
                end else if (free_slots == (AW+1)'(1)) begin
                    we0  = 1'b1;
                    nwr  = 2'd1;
                    drop = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        count_d  = count_q + (AW+1)'(nwr) - (AW+1)'(pop);
        wr_ptr_d = wr_ptr_q + AW'(nwr);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        ovf_d    = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO bookkeeping registers; reset discards every queued record.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Record storage: one register per slot, two write ports
    // ------------------------------------------------------------------
    logic [W-1:0] slot_rd [Y];

    generate
        for (gi = 0; gi < Y; gi++) begin : g_slot
            logic [W-1:0] slot_q;

            // Slot captures the first or second record aimed at it this cycle.
            always_ff @(posedge clk) begin
                if (we0 && (wa0 == AW'(gi))) begin
                    slot_q <= wd0;
                end else if (we1 && (wa1 == AW'(gi))) begin
                    slot_q <= wd1;
                end
            end

            assign slot_rd[gi] = slot_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read side: head shown combinationally, gated to zero when empty
    // ------------------------------------------------------------------
    assign ev_valid = (count_q != '0);
    assign ev_data  = ev_valid ? slot_rd[rd_ptr_q] : '0;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_cd_event_fifo.sv
// Bench for cd_event_fifo (X=2, Y=4, Z=3): directed scenarios with literal
// expectations plus a queue-based reference model compared every cycle.
module tb_cd_event_fifo;

    localparam int X = 2;
    localparam int Y = 4;
    localparam int Z = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         c = 1'b0;
    logic         d = 1'b0;
    logic         clr_ovf = 1'b0;
    logic         ev_ready = 1'b0;
    logic         ev_valid;
    logic [Z+1:0] ev_data;
    logic [1:0]   level;
    logic         ovf;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    cd_event_fifo #(X, Y, Z) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .c        (c),
        .d        (d),
        .clr_ovf  (clr_ovf),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_data  (ev_data),
        .level    (level),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: records kept in a queue, debounce judged from the
    // history of registered samples. State here is "after the latest edge".
    // ------------------------------------------------------------------
    bit           m_cq = 1'b0;
    bit           m_dq = 1'b0;
    bit           m_lc = 1'b0;
    bit           m_ld = 1'b0;
    bit           m_ovf = 1'b0;
    logic [Z-1:0] m_ts = '0;
    bit           hc[$];
    bit           hd[$];
    logic [Z+1:0] m_q[$];

    always @(negedge clk) begin : model
        bit           fc;
        bit           fd;
        bit           pop;
        bit           drop;
        int           nfree;
        logic         exp_valid;
        logic [Z+1:0] exp_data;

        if (chk_en) begin
            exp_valid = (m_q.size() != 0);
            exp_data  = exp_valid ? m_q[0] : '0;
            check("cyc_valid", 8'(ev_valid), 8'(exp_valid));
            check("cyc_data",  8'(ev_data),  8'(exp_data));
            check("cyc_level", 8'(level),    8'({m_ld, m_lc}));
            check("cyc_ovf",   8'(ovf),      8'(m_ovf));
        end

        if (!rst_n) begin
            m_cq = 1'b0; m_dq = 1'b0; m_lc = 1'b0; m_ld = 1'b0;
            m_ovf = 1'b0; m_ts = '0;
            hc.delete(); hd.delete(); m_q.delete();
        end else begin
            pop = (m_q.size() != 0) && ev_ready;
            hc.push_back(m_cq);
            if (hc.size() > X) void'(hc.pop_front());
            hd.push_back(m_dq);
            if (hd.size() > X) void'(hd.pop_front());
            // A channel flips when its last X registered samples all disagree.
            fc = (hc.size() == X);
            foreach (hc[i]) if (hc[i] == m_lc) fc = 1'b0;
            fd = (hd.size() == X);
            foreach (hd[i]) if (hd[i] == m_ld) fd = 1'b0;
            nfree = Y - m_q.size();
            drop  = 1'b0;
            if (fc) begin
                if (nfree > 0) begin m_q.push_back({m_ts, 1'b0, ~m_lc}); nfree--; end
                else drop = 1'b1;
            end
            if (fd) begin
                if (nfree > 0) begin m_q.push_back({m_ts, 1'b1, ~m_ld}); nfree--; end
                else drop = 1'b1;
            end
            if (pop) void'(m_q.pop_front());
            if (fc) m_lc = ~m_lc;
            if (fd) m_ld = ~m_ld;
            if (drop) m_ovf = 1'b1;
            else if (clr_ovf) m_ovf = 1'b0;
            m_ts = m_ts + 1'b1;
            m_cq = c;
            m_dq = d;
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus; inputs change 1 time unit after each rising edge
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; c = 1'b0; d = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
        tick(3);
        rst_n = 1'b1;
    endtask

    initial begin
        // Reset held with c=d=1, then c=1 held after release.
        rst_n = 1'b0; c = 1'b1; d = 1'b1;
        tick(1);
        chk_en = 1'b1;
        tick(2);
        check("rst_valid", 8'(ev_valid), 8'd0);
        check("rst_level", 8'(level), 8'd0);
        check("rst_ovf",   8'(ovf), 8'd0);
        check("rst_data",  8'(ev_data), 8'd0);
        rst_n = 1'b1; d = 1'b0;
        tick(2);
        check("rel_not_yet", 8'(ev_valid), 8'd0);
        tick(1);
        check("rel_valid", 8'(ev_valid), 8'd1);
        check("rel_data",  8'(ev_data), 8'd9);     // {ts=2, C, 1}
        check("rel_level", 8'(level), 8'b01);
        $display("reset scenario: head=%0h level=%b", ev_data, level);

        // Glitch rejection, then a 2-cycle pulse that is accepted.
        do_reset();
        c = 1'b1; tick(1);
        c = 1'b0; tick(4);
        check("glitch_level", 8'(level), 8'd0);
        check("glitch_valid", 8'(ev_valid), 8'd0);
        c = 1'b1; tick(3);
        check("accept_level", 8'(level), 8'b01);
        check("accept_data",  8'(ev_data), 8'd29);  // {ts=7, C, 1}
        $display("glitch scenario: head=%0h level=%b", ev_data, level);

        // Simultaneous C and D edges written with ts=5.
        do_reset();
        tick(3);
        c = 1'b1; d = 1'b1;
        tick(3);
        check("sim_first",  8'(ev_data), 8'd21);    // {5, C, 1}
        check("sim_level",  8'(level), 8'b11);
        ev_ready = 1'b1;
        tick(1);
        check("sim_second", 8'(ev_data), 8'd23);    // {5, D, 1}
        tick(1);
        check("sim_empty",  8'(ev_valid), 8'd0);
        ev_ready = 1'b0;
        $display("simultaneous scenario: drained, valid=%b", ev_valid);

        // Overflow: three C events then a C+D pair with one slot left.
        do_reset();
        c = 1'b1; tick(3);
        c = 1'b0; tick(3);
        c = 1'b1; tick(3);
        c = 1'b0; d = 1'b1; tick(3);
        check("ovf_set",   8'(ovf), 8'd1);
        check("ovf_level", 8'(level), 8'b10);
        check("ovf_head0", 8'(ev_data), 8'd9);      // {2, C, 1}
        ev_ready = 1'b1;
        tick(1);
        check("ovf_head1", 8'(ev_data), 8'd20);     // {5, C, 0}
        tick(1);
        check("ovf_head2", 8'(ev_data), 8'd1);      // {0, C, 1}
        tick(1);
        check("ovf_head3", 8'(ev_data), 8'd12);     // {3, C, 0}
        tick(1);
        check("ovf_drained", 8'(ev_valid), 8'd0);
        check("ovf_sticky",  8'(ovf), 8'd1);
        ev_ready = 1'b0;
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        check("ovf_cleared", 8'(ovf), 8'd0);
        $display("overflow scenario: ovf=%b after clear", ovf);

        // Timestamp wrap: accepted edges 9 cycles apart, first at ts=6.
        do_reset();
        ev_ready = 1'b1;
        tick(4);
        c = 1'b1; tick(3);
        check("wrap_first", 8'(ev_data), 8'd25);    // {6, C, 1}
        tick(6);
        c = 1'b0; tick(3);
        check("wrap_second", 8'(ev_data), 8'd28);   // {7, C, 0}
        ev_ready = 1'b0;
        $display("wrap scenario: head=%0h", ev_data);

        // Full FIFO with a pop and a new event in the same cycle.
        do_reset();
        c = 1'b1; tick(3);
        c = 1'b0; tick(3);
        c = 1'b1; tick(3);
        c = 1'b0; tick(3);
        c = 1'b1; tick(2);
        ev_ready = 1'b1;
        tick(1);
        check("fullpop_ovf",   8'(ovf), 8'd1);
        check("fullpop_head",  8'(ev_data), 8'd20);
        check("fullpop_level", 8'(level), 8'b01);
        tick(2);
        check("fullpop_last",  8'(ev_data), 8'd12);
        tick(1);
        check("fullpop_empty", 8'(ev_valid), 8'd0);
        ev_ready = 1'b0;
        $display("full+pop scenario: valid=%b ovf=%b", ev_valid, ovf);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
